// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, assembles each 32-bit instruction from
// four byte reads and holds it for the core until it signals completion.
module instr_fetch_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [31:0]       PC,
    output logic [31:0]       INSTRUCTION,
    output logic              INSTR_VALID,
    input  logic              ADVANCE,
    input  logic              BRANCH,
    input  logic [31:0]       BRANCH_TARGET,
    output logic              FAULT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_READ,
    input  logic [7:0]        MEM_RDATA,
    input  logic              MEM_READY
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              fault_q, fault_d;

    logic [31:0]       next_pc;
    logic              next_legal;

    assign next_pc    = BRANCH ? BRANCH_TARGET : pc_q + 32'd4;
    assign next_legal = (next_pc[1:0] == 2'b00) && (next_pc[31:ADDR_W] == '0);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        fault_d    = fault_q;

        case (state_q)
            FETCH: begin
                valid_d    = 1'b0;
                mem_read_d = 1'b1;
                // A byte only counts once the request is actually on the bus.
                if (mem_read_q && MEM_READY) begin
                    instr_d[{k_q, 3'b000} +: 8] = MEM_RDATA;
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d    = HOLD;
                        valid_d    = 1'b1;
                        mem_read_d = 1'b0;
                        k_d        = 2'd0;
                    end
                end
                if (mem_read_d) begin
                    mem_addr_d = pc_q[ADDR_W-1:0] + ADDR_W'(k_d);
                end
            end
            HOLD: begin
                if (ADVANCE) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    k_d     = 2'd0;
                    if (next_legal) begin
                        state_d    = FETCH;
                        mem_read_d = 1'b1;
                        mem_addr_d = next_pc[ADDR_W-1:0];
                    end else begin
                        state_d    = HALT;
                        mem_read_d = 1'b0;
                        fault_d    = 1'b1;
                    end
                end
            end
            HALT: begin
                valid_d    = 1'b0;
                mem_read_d = 1'b0;
                fault_d    = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= FETCH;
            k_q        <= 2'd0;
            pc_q       <= 32'd0;
            instr_q    <= 32'd0;
            valid_q    <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            fault_q    <= fault_d;
        end
    end

    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = valid_q;
    assign MEM_READ    = mem_read_q;
    assign MEM_ADDR    = mem_addr_q;
    assign FAULT       = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a byte-wide memory model and
// hand-computed expectations.
module tb_instr_fetch_ctrl;

    localparam int ADDR_W = 10;

    logic              CLK;
    logic              RESET;
    logic [31:0]       PC;
    logic [31:0]       INSTRUCTION;
    logic              INSTR_VALID;
    logic              ADVANCE;
    logic              BRANCH;
    logic [31:0]       BRANCH_TARGET;
    logic              FAULT;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_READ;
    logic [7:0]        MEM_RDATA;
    logic              MEM_READY;

    logic [7:0]        mem [1024];
    logic              ready_en;
    int                n_checks;
    int                n_err;

    logic [31:0] prog [7];

    instr_fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PC(PC),
        .INSTRUCTION(INSTRUCTION),
        .INSTR_VALID(INSTR_VALID),
        .ADVANCE(ADVANCE),
        .BRANCH(BRANCH),
        .BRANCH_TARGET(BRANCH_TARGET),
        .FAULT(FAULT),
        .MEM_ADDR(MEM_ADDR),
        .MEM_READ(MEM_READ),
        .MEM_RDATA(MEM_RDATA),
        .MEM_READY(MEM_READY)
    );

    assign MEM_RDATA = mem[MEM_ADDR];
    assign MEM_READY = ready_en;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] w);
        mem[addr]     = w[7:0];
        mem[addr + 1] = w[15:8];
        mem[addr + 2] = w[23:16];
        mem[addr + 3] = w[31:24];
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"},    PC, 32'd0);
        chk({tag, "_instr"}, INSTRUCTION, 32'd0);
        chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd0);
        chk({tag, "_read"},  {31'd0, MEM_READ}, 32'd0);
        chk({tag, "_addr"},  {22'd0, MEM_ADDR}, 32'd0);
        chk({tag, "_fault"}, {31'd0, FAULT}, 32'd0);
    endtask

    task automatic chk_fault(input string tag, input logic [31:0] exp_pc);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_fault"}, {31'd0, FAULT}, 32'd1);
            chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd0);
            chk({tag, "_read"},  {31'd0, MEM_READ}, 32'd0);
            chk({tag, "_pc"},    PC, exp_pc);
            ADVANCE = 1'b1;
            BRANCH  = 1'b0;
            step();
        end
        ADVANCE = 1'b0;
    endtask

    // Waits for INSTR_VALID and returns the edges taken since fetch entry.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!INSTR_VALID && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        ADVANCE = 1'b0;
        BRANCH = 1'b0;
        BRANCH_TARGET = 32'd0;
        step();
        RESET = 1'b0;
    endtask

    int cyc;

    initial begin
        n_checks = 0;
        n_err = 0;
        prog[0] = 32'h0000000B;
        prog[1] = 32'h11223344;
        prog[2] = 32'hDEADBEEF;
        prog[3] = 32'h01020304;
        prog[4] = 32'hCAFEF00D;
        prog[5] = 32'h8BADF00D;
        prog[6] = 32'h76543210;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 7; i++) load_word(4 * i, prog[i]);
        load_word(28, 32'h2468ACE0);
        load_word(32'h40, 32'hFEEDC0DE);
        load_word(32'h3FC, 32'h13579BDF);

        ready_en = 1'b1;
        RESET = 1'b1;
        ADVANCE = 1'b0;
        BRANCH = 1'b0;
        BRANCH_TARGET = 32'd0;
        step();
        step();
        chk_zero("reset");
        RESET = 1'b0;

        // First fetch after release, zero-wait memory
        step();
        chk("first_read", {31'd0, MEM_READ}, 32'd1);
        chk("first_addr0", {22'd0, MEM_ADDR}, 32'd0);
        step();
        chk("addr1", {22'd0, MEM_ADDR}, 32'd1);
        step();
        chk("addr2", {22'd0, MEM_ADDR}, 32'd2);
        step();
        chk("addr3", {22'd0, MEM_ADDR}, 32'd3);
        chk("valid_before4", {31'd0, INSTR_VALID}, 32'd0);
        step();
        chk("valid_at4", {31'd0, INSTR_VALID}, 32'd1);
        chk("instr0", INSTRUCTION, 32'h0000000B);
        chk("pc0", PC, 32'd0);
        chk("read_drop", {31'd0, MEM_READ}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("hold_instr", INSTRUCTION, 32'h0000000B);
        chk("hold_pc", PC, 32'd0);

        // Sequential program, ADVANCE in the first HOLD cycle
        for (int i = 1; i < 7; i++) begin
            ADVANCE = 1'b1;
            step();
            ADVANCE = 1'b0;
            chk("seq_pc", PC, 32'(4 * i));
            chk("seq_valid_fall", {31'd0, INSTR_VALID}, 32'd0);
            chk("seq_addr", {22'd0, MEM_ADDR}, 32'(4 * i));
            wait_valid(cyc);
            chk("seq_fetch_cycles", 32'(cyc), 32'd4);
            chk("seq_instr", INSTRUCTION, prog[i]);
        end

        // Wait states on byte 2 of the instruction at 28
        ADVANCE = 1'b1;
        step();
        ADVANCE = 1'b0;
        step();
        step();
        chk("ws_addr", {22'd0, MEM_ADDR}, 32'd30);
        ready_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_addr_stable", {22'd0, MEM_ADDR}, 32'd30);
            chk("ws_read", {31'd0, MEM_READ}, 32'd1);
        end
        ready_en = 1'b1;
        step();
        chk("ws_valid_early", {31'd0, INSTR_VALID}, 32'd0);
        step();
        chk("ws_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("ws_instr", INSTRUCTION, 32'h2468ACE0);
        chk("ws_pc", PC, 32'd28);

        // Branch back to 8, then branch from 8 to 0x40
        ADVANCE = 1'b1;
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'd8;
        step();
        ADVANCE = 1'b0;
        chk("br8_pc", PC, 32'd8);
        wait_valid(cyc);
        chk("br8_instr", INSTRUCTION, 32'hDEADBEEF);
        BRANCH_TARGET = 32'h40;
        step();
        step();
        chk("br_noadv_pc", PC, 32'd8);
        chk("br_noadv_valid", {31'd0, INSTR_VALID}, 32'd1);
        ADVANCE = 1'b1;
        step();
        ADVANCE = 1'b0;
        BRANCH = 1'b0;
        chk("br40_pc", PC, 32'h40);
        chk("br40_addr", {22'd0, MEM_ADDR}, 32'h40);
        chk("br40_read", {31'd0, MEM_READ}, 32'd1);
        wait_valid(cyc);
        chk("br40_cycles", 32'(cyc), 32'd4);
        chk("br40_instr", INSTRUCTION, 32'hFEEDC0DE);

        // Fault: misaligned branch target
        ADVANCE = 1'b1;
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'h42;
        step();
        chk_fault("f_mis", 32'h42);

        // Fault: branch target outside memory
        do_reset();
        chk_zero("reset2");
        wait_valid(cyc);
        chk("r2_instr", INSTRUCTION, 32'h0000000B);
        ADVANCE = 1'b1;
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'h400;
        step();
        chk_fault("f_oob", 32'h400);

        // Fault: sequential step past the last word
        do_reset();
        wait_valid(cyc);
        ADVANCE = 1'b1;
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'h3FC;
        step();
        ADVANCE = 1'b0;
        BRANCH = 1'b0;
        wait_valid(cyc);
        chk("top_pc", PC, 32'h3FC);
        chk("top_instr", INSTRUCTION, 32'h13579BDF);
        ADVANCE = 1'b1;
        step();
        chk_fault("f_wrap", 32'h400);

        // Reset in the middle of a fetch while a byte is being returned
        do_reset();
        step();
        step();
        chk("mid_addr1", {22'd0, MEM_ADDR}, 32'd1);
        RESET = 1'b1;
        step();
        chk_zero("mid_reset");
        RESET = 1'b0;
        step();
        chk("mid_restart_read", {31'd0, MEM_READ}, 32'd1);
        chk("mid_restart_addr", {22'd0, MEM_ADDR}, 32'd0);
        wait_valid(cyc);
        chk("mid_cycles", 32'(cyc), 32'd4);
        chk("mid_instr", INSTRUCTION, 32'h0000000B);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Sequencer between the CPU core and the byte-wide instruction memory. It owns the program counter, fetches each 32-bit instruction as four byte reads over a ready/read handshake, and presents the assembled word to the core with a valid flag. It advances to PC+4 or to a branch target only when the core signals completion. It replaces the testbench's direct array indexing and the core's free-running PC.

## Interface
- ADDR_W, 10, instruction-memory byte-address width (1024 bytes)
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- PC  out  32  address of the instruction currently fetched or held
- INSTRUCTION  out  32  assembled instruction; byte at PC+0 in [7:0], PC+3 in [31:24]
- INSTR_VALID  out  1  INSTRUCTION is complete and stable
- ADVANCE  in  1  core has finished the held instruction; sampled only while INSTR_VALID=1
- BRANCH  in  1  with ADVANCE: next PC is BRANCH_TARGET instead of PC+4
- BRANCH_TARGET  in  32  branch destination byte address
- FAULT  out  1  sticky: next PC misaligned or outside memory
- MEM_ADDR  out  ADDR_W  byte address to instruction memory
- MEM_READ  out  1  read request; MEM_ADDR is stable while MEM_READ=1 and MEM_READY=0
- MEM_RDATA  in  8  read data; valid when MEM_READY=1
- MEM_READY  in  1  read complete this cycle; ignored when MEM_READ=0

## Operation
- States: FETCH, HOLD, HALT. Byte counter k is 2 bits.
- Reset at a rising edge with RESET=1 sets all outputs to zero: PC, INSTRUCTION, INSTR_VALID, MEM_READ, MEM_ADDR and FAULT. It also sets k=0 and the state to FETCH.
- Reset aborts any fetch in progress. A byte returned during the reset cycle is discarded.
- FETCH: MEM_READ=1 and MEM_ADDR=PC[ADDR_W-1:0]+k, with the address add modulo 2^ADDR_W.
  - Each edge with MEM_READY=1 writes MEM_RDATA into INSTRUCTION[8k+7:8k] and increments k.
  - Capturing the byte at k=3 moves to HOLD, sets k=0 and drops MEM_READ.
  - With MEM_READY=0, all fetch state holds and the fetch waits indefinitely.
- During FETCH, INSTR_VALID=0. INSTRUCTION bytes not yet fetched keep the previous instruction's values. The core must not use INSTRUCTION while INSTR_VALID=0.
- HOLD: INSTR_VALID=1, MEM_READ=0, and INSTRUCTION and PC are held.
  - Edge with ADVANCE=1 and BRANCH=0: next PC = PC+4, 32-bit wrap.
  - Edge with ADVANCE=1 and BRANCH=1: next PC = BRANCH_TARGET.
  - Next PC legal (next_pc[1:0]=0 and next_pc[31:ADDR_W]=0): PC <= next PC and go to FETCH.
  - Next PC illegal: go to HALT, FAULT <= 1, PC <= the offending next PC.
- HALT: INSTR_VALID=0, MEM_READ=0, FAULT=1. ADVANCE, BRANCH and MEM_READY are ignored. Only RESET exits.
- ADVANCE and BRANCH are ignored outside HOLD. BRANCH without ADVANCE has no effect.
- PC+4 from address 2^ADDR_W-4 exceeds memory and therefore faults. There is no silent wrap to 0.

## Timing
- After the RESET-deassert edge, MEM_READ=1 with MEM_ADDR=0 in the first cycle.
- With zero-wait memory (MEM_READY=1 in the same cycle as MEM_READ):
  - fetch takes 4 cycles;
  - INSTR_VALID rises 4 edges after FETCH entry;
  - ADVANCE in the first HOLD cycle gives a 5-cycle minimum instruction period.
- Each wait cycle of MEM_READY=0 adds exactly one cycle to the fetch.
- PC updates on the same edge that leaves HOLD. INSTR_VALID falls on that edge.
- FAULT rises on the edge that samples an illegal ADVANCE. It is never asserted together with INSTR_VALID.
- All outputs are registered. There are no combinational paths from ADVANCE, BRANCH or MEM_READY to any output.

## Test plan
- Reset, memory bytes 0..3 = 0B,00,00,00, zero-wait, ADVANCE held low -> MEM_ADDR steps 0,1,2,3; INSTR_VALID=1 on the 4th edge with INSTRUCTION=32'h0000000B and PC=0; state holds indefinitely.
- Seven-instruction program, ADVANCE pulsed in each HOLD -> PC sequence 0,4,...,24; each INSTRUCTION matches the little-endian words in memory; period is 5 cycles.
- MEM_READY low for 3 cycles on byte 2 -> MEM_ADDR=PC+2 is stable throughout; the valid instruction arrives 3 cycles later and is correct.
- In HOLD at PC=8, ADVANCE=1, BRANCH=1, BRANCH_TARGET=32'h40 -> PC=32'h40, MEM_ADDR=32'h40; BRANCH=1 with ADVANCE=0 -> no change.
- Faults, each checked for FAULT=1, INSTR_VALID=0, MEM_READ=0 and held until RESET:
  - BRANCH_TARGET=32'h42 -> fault;
  - BRANCH_TARGET=32'h400 with ADDR_W=10 -> fault;
  - PC+4 from 32'h3FC -> fault.
- RESET asserted mid-fetch while MEM_READY=1 at byte 1 -> the next edge gives all outputs zero and the byte is discarded; the fetch restarts at address 0 after release.
